enc_buffer: RTL and testbench

//  Input elastic buffer of the RS encoder datapath; sits directly upstream of the formatter.

---
 rtl/enc_buffer_pkg.sv | 23 ++
 rtl/enc_buf_shift.sv | 38 +++
 rtl/enc_buffer.sv | 87 ++++++++
 tb/tb_enc_buffer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/enc_buffer_pkg.sv
// Shared encoder constants and phase types used across the RS encoder datapath.
package enc_buffer_pkg;

   localparam int unsigned ENC_SYM_NUM = 8;
   localparam int unsigned EGF_ORDER   = 8;
   localparam int unsigned BUF_LEN     = 2*ENC_SYM_NUM-1;
   localparam int unsigned CNT_W       = $clog2(ENC_SYM_NUM+1);

   typedef enum logic [1:0] {
      CON_IDLE,
      CON_DATA,
      CON_PARITY,
      CON_FLUSH
   } CON_PHASE;

   typedef enum logic [1:0] {
      FOR_IDLE,
      FOR_HEAD,
      FOR_BODY,
      FOR_TAIL
   } FOR_PHASE;

endpackage

// File: rtl/enc_buf_shift.sv
// Next-window computation for enc_buffer: drop the p oldest symbols (p clamped
// to occupancy) and append a full input word directly below the survivors.
module enc_buf_shift
   import enc_buffer_pkg::*;
(
   input  logic [BUF_LEN-1:0][EGF_ORDER-1:0]     cur_data,
   input  logic [CNT_W-1:0]                      cur_valid,
   input  logic [CNT_W-1:0]                      pop,
   input  logic                                  push,
   input  logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0] in_data,
   output logic [BUF_LEN-1:0][EGF_ORDER-1:0]     nxt_data,
   output logic [CNT_W-1:0]                      nxt_valid
);

   logic [BUF_LEN*EGF_ORDER-1:0] kept_flat;
   logic [BUF_LEN*EGF_ORDER-1:0] ins_flat;
   int unsigned                  p_i;
   int unsigned                  r_i;

   // Survivors shift up by p slots; the new word is top-aligned then shifted down by r
   // slots, so each output slot just selects survivor, new symbol, or zero.
   always_comb begin
      p_i       = (pop > cur_valid) ? 32'(cur_valid) : 32'(pop);
      r_i       = 32'(cur_valid) - p_i;
      kept_flat = cur_data << (p_i*EGF_ORDER);
      ins_flat  = {in_data, {((BUF_LEN-ENC_SYM_NUM)*EGF_ORDER){1'b0}}} >> (r_i*EGF_ORDER);
      nxt_data  = '0;
      for (int unsigned k = 0; k < BUF_LEN; k++) begin
         if (k < r_i) begin
            nxt_data[BUF_LEN-1-k] = kept_flat[(BUF_LEN-1-k)*EGF_ORDER +: EGF_ORDER];
         end else if (push && (k < r_i + ENC_SYM_NUM)) begin
            nxt_data[BUF_LEN-1-k] = ins_flat[(BUF_LEN-1-k)*EGF_ORDER +: EGF_ORDER];
         end
      end
      nxt_valid = CNT_W'(r_i + (push ? ENC_SYM_NUM : 32'd0));
   end

endmodule

// File: rtl/enc_buffer.sv
// Input elastic buffer of the RS encoder datapath, upstream of the formatter.
// Optional macro ENC_BUF_CHECK_EN enables the sticky underflow flag buf_error.
module enc_buffer
   import enc_buffer_pkg::*;
(
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0] in_data,
   input  logic                                  con_flush,
   input  logic [CNT_W-1:0]                      con_pop,
   output logic [CNT_W-1:0]                      buf_valid,
   output logic [BUF_LEN-1:0][EGF_ORDER-1:0]     buf_data,
   output logic                                  buf_error
);

   logic [BUF_LEN-1:0][EGF_ORDER-1:0] data_q, data_d, shf_data;
   logic [CNT_W-1:0]                  valid_q, valid_d, shf_valid;
   logic                              push;

   // Ready depends only on registered occupancy and flush, never on pop or in_valid.
   assign in_ready = !con_flush && (valid_q < CNT_W'(ENC_SYM_NUM));
   assign push     = in_valid && in_ready;

   enc_buf_shift u_shift (
      .cur_data  (data_q),
      .cur_valid (valid_q),
      .pop       (con_pop),
      .push      (push),
      .in_data   (in_data),
      .nxt_data  (shf_data),
      .nxt_valid (shf_valid)
   );

   // Next window: shifted result unless flush clears everything.
   always_comb begin
      data_d  = shf_data;
      valid_d = shf_valid;
      if (con_flush) begin
         data_d  = '0;
         valid_d = '0;
      end
   end

   // Window and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign buf_data  = data_q;
   assign buf_valid = valid_q;

`ifdef ENC_BUF_CHECK_EN
   logic error_q, error_d;

   // Sticky underflow: set when the controller pops more than is held, cleared by flush.
   always_comb begin
      error_d = error_q;
      if (con_flush) begin
         error_d = 1'b0;
      end else if (con_pop > valid_q) begin
         error_d = 1'b1;
      end
   end

   // Underflow flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign buf_error = error_q;
`else
   assign buf_error = 1'b0;
`endif

endmodule

// File: tb/tb_enc_buffer.sv
// Self-checking bench for enc_buffer using a symbol-queue scoreboard.
module tb_enc_buffer;
   import enc_buffer_pkg::*;

   logic                                  clk;
   logic                                  rst_n;
   logic                                  in_valid;
   logic                                  in_ready;
   logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0] in_data;
   logic                                  con_flush;
   logic [CNT_W-1:0]                      con_pop;
   logic [CNT_W-1:0]                      buf_valid;
   logic [BUF_LEN-1:0][EGF_ORDER-1:0]     buf_data;
   logic                                  buf_error;

   int unsigned total;
   int unsigned bad;

   logic [EGF_ORDER-1:0] sym_q[$];
   logic                 exp_err;

   enc_buffer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .con_flush (con_flush),
      .con_pop   (con_pop),
      .buf_valid (buf_valid),
      .buf_data  (buf_data),
      .buf_error (buf_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0] mk_word(input int unsigned base);
      logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0] w;
      for (int unsigned j = 0; j < ENC_SYM_NUM; j++) w[ENC_SYM_NUM-1-j] = EGF_ORDER'(base + j);
      return w;
   endfunction

   function automatic logic [BUF_LEN-1:0][EGF_ORDER-1:0] exp_window();
      logic [BUF_LEN-1:0][EGF_ORDER-1:0] w;
      w = '0;
      for (int i = 0; i < sym_q.size(); i++) w[BUF_LEN-1-i] = sym_q[i];
      return w;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, 128'(buf_valid), 128'(sym_q.size()));
      check({tag, ".data"},  128'(buf_data),  128'(exp_window()));
      check({tag, ".error"}, 128'(buf_error), 128'(exp_err));
   endtask

   // One clock cycle: drive at negedge, check ready, update model, check after posedge.
   task automatic step(input string tag, input logic v,
                       input logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0] w,
                       input int unsigned pop, input logic fl);
      logic        exp_rdy;
      int unsigned p;
      @(negedge clk);
      in_valid  = v;
      in_data   = w;
      con_pop   = CNT_W'(pop);
      con_flush = fl;
      #1;
      exp_rdy = !fl && (sym_q.size() < ENC_SYM_NUM);
      check({tag, ".ready"}, 128'(in_ready), 128'(exp_rdy));
      if (fl) begin
         sym_q.delete();
         exp_err = 1'b0;
      end else begin
`ifdef ENC_BUF_CHECK_EN
         if (pop > sym_q.size()) exp_err = 1'b1;
`endif
         p = (pop > sym_q.size()) ? sym_q.size() : pop;
         for (int unsigned i = 0; i < p; i++) void'(sym_q.pop_front());
         if (v && exp_rdy)
            for (int unsigned j = 0; j < ENC_SYM_NUM; j++) sym_q.push_back(w[ENC_SYM_NUM-1-j]);
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      exp_err   = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      con_flush = 1'b0;
      con_pop   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset.ready", 128'(in_ready), 128'(1'b1));

      // Fill from empty: 0x01..0x08 lands at the top, ready drops.
      step("fill", 1'b1, mk_word(32'h01), 0, 1'b0);
      check("fill.slot14", 128'(buf_data[14]), 128'h01);
      check("fill.slot7",  128'(buf_data[7]),  128'h08);
      #1;
      check("fill.ready", 128'(in_ready), 128'(1'b0));

      // Occupancy 5 (0x11..0x15), then push 0x21..0x28 with pop 3.
      step("flush0", 1'b0, '0, 0, 1'b1);
      step("pre5", 1'b1, mk_word(32'h0E), 0, 1'b0);
      step("pop3", 1'b0, '0, 3, 1'b0);
      step("pushpop", 1'b1, mk_word(32'h21), 3, 1'b0);
      check("pushpop.slot14", 128'(buf_data[14]), 128'h14);
      check("pushpop.slot5",  128'(buf_data[5]),  128'h28);

      // Sustained source and full pops: stream order held by the scoreboard.
      step("flush1", 1'b0, '0, 0, 1'b1);
      step("s0", 1'b1, mk_word(32'h00), 0, 1'b0);
      for (int unsigned i = 1; i <= 100; i++) step("stream", 1'b1, mk_word(i*8), 8, 1'b0);

      // Underflow: hold 3, pop 6; flush clears the flag.
      step("flush2", 1'b0, '0, 0, 1'b1);
      step("u0", 1'b1, mk_word(32'h40), 0, 1'b0);
      step("u1", 1'b0, '0, 5, 1'b0);
      step("under", 1'b0, '0, 6, 1'b0);
      step("under_hold", 1'b0, '0, 0, 1'b0);

      // Flush with occupancy 12 and a valid word offered.
      step("flush3", 1'b0, '0, 0, 1'b1);
      step("f0", 1'b1, mk_word(32'h50), 0, 1'b0);
      step("f1", 1'b0, '0, 4, 1'b0);
      step("f2", 1'b1, mk_word(32'h60), 0, 1'b0);
      check("f2.valid12", 128'(buf_valid), 128'd12);
      step("flush12", 1'b1, mk_word(32'h70), 0, 1'b1);

      // Random traffic, occasional flush and over-pop.
      for (int unsigned i = 0; i < 300; i++)
         step("rand", 1'($urandom_range(0, 1)), mk_word($urandom_range(0, 255)),
              $urandom_range(0, 8), ($urandom_range(0, 15) == 0));

      // Asynchronous reset mid-cycle at occupancy 9.
      step("flush4", 1'b0, '0, 0, 1'b1);
      step("r0", 1'b1, mk_word(32'h80), 0, 1'b0);
      step("r1", 1'b0, '0, 7, 1'b0);
      step("r2", 1'b1, mk_word(32'h90), 0, 1'b0);
      check("r2.valid9", 128'(buf_valid), 128'd9);
      in_valid = 1'b0;
      con_pop  = '0;
      #2;
      rst_n = 1'b0;
      #1;
      sym_q.delete();
      exp_err = 1'b0;
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("async_rst.ready", 128'(in_ready), 128'(1'b1));
      step("post_rst", 1'b1, mk_word(32'hA0), 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
